// File: rtl/ram_bist.sv
// ram_bist: built-in self-test controller for one single-port synchronous RAM.
// A start pulse taken in IDLE or DONE runs a three-phase checkerboard march:
//   WR0      ascending write of PAT(a)
//   RD1/CK1  ascending read, compare against PAT(a), then write ~PAT(a)
//   RD2/CK2  descending read, compare against ~PAT(a)
// The run stops at the first mismatch and reports its address and data.
//
// Ports:
//   clk       rising-edge clock shared with the RAM
//   rs        asynchronous active-low reset
//   start     begin a run (ignored while busy)
//   busy      controller owns the RAM port
//   done      run finished, held until the next accepted start
//   pass      1 = no mismatch (valid while done)
//   fail_add  address of the first mismatch
//   fail_exp  expected data at the first mismatch
//   fail_got  data read at the first mismatch
//   ram_wr    1 = write, 0 = read
//   ram_add   RAM address
//   ram_din   RAM write data
//   ram_dout  RAM read data, valid the cycle after a read address
module ram_bist #(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rs,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_add,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got,
  output logic          ram_wr,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD1  = 3'd2,
    CK1  = 3'd3,
    RD2  = 3'd4,
    CK2  = 3'd5,
    DONE = 3'd6
  } state_e;

  // Alternating bits with the LSB set (0101 for a 4-bit word).
  function automatic logic [DW-1:0] base_pat();
    logic [DW-1:0] b;
    for (int i = 0; i < DW; i++) b[i] = (i % 2 == 0);
    return b;
  endfunction

  localparam logic [DW-1:0] BASE = base_pat();
  localparam logic [AW-1:0] LAST = '1;

  state_e        st_q, st_d;
  logic [AW-1:0] a_q, a_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_add_q, fail_add_d;
  logic [DW-1:0] fail_exp_q, fail_exp_d;
  logic [DW-1:0] fail_got_q, fail_got_d;

  // Checkerboard: the pattern inverts on every odd address.
  logic [DW-1:0] pat_a;
  assign pat_a = a_q[0] ? ~BASE : BASE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      st_q       <= IDLE;
      a_q        <= '0;
      pass_q     <= 1'b0;
      fail_add_q <= '0;
      fail_exp_q <= '0;
      fail_got_q <= '0;
    end else begin
      st_q       <= st_d;
      a_q        <= a_d;
      pass_q     <= pass_d;
      fail_add_q <= fail_add_d;
      fail_exp_q <= fail_exp_d;
      fail_got_q <= fail_got_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    st_d       = st_q;
    a_d        = a_q;
    pass_d     = pass_q;
    fail_add_d = fail_add_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;

    unique case (st_q)
      IDLE, DONE: begin
        if (start) begin
          st_d       = WR0;
          a_d        = '0;
          pass_d     = 1'b0;
          fail_add_d = '0;
          fail_exp_d = '0;
          fail_got_d = '0;
        end
      end

      WR0: begin
        if (a_q == LAST) begin
          st_d = RD1;
          a_d  = '0;
        end else begin
          a_d = a_q + AW'(1);
        end
      end

      RD1: st_d = CK1;

      CK1: begin
        if (ram_dout != pat_a) begin
          st_d       = DONE;
          pass_d     = 1'b0;
          fail_add_d = a_q;
          fail_exp_d = pat_a;
          fail_got_d = ram_dout;
        end else if (a_q == LAST) begin
          // Phase 3 starts from the top address; the counter never wraps.
          st_d = RD2;
        end else begin
          st_d = RD1;
          a_d  = a_q + AW'(1);
        end
      end

      RD2: st_d = CK2;

      CK2: begin
        if (ram_dout != ~pat_a) begin
          st_d       = DONE;
          pass_d     = 1'b0;
          fail_add_d = a_q;
          fail_exp_d = ~pat_a;
          fail_got_d = ram_dout;
        end else if (a_q == '0) begin
          st_d   = DONE;
          pass_d = 1'b1;
        end else begin
          st_d = RD2;
          a_d  = a_q - AW'(1);
        end
      end

      default: st_d = IDLE;
    endcase
  end

  // RAM port decodes straight from state so it is quiet under reset.
  always_comb begin
    ram_wr  = 1'b0;
    ram_din = '0;
    unique case (st_q)
      WR0: begin
        ram_wr  = 1'b1;
        ram_din = pat_a;
      end
      CK1: begin
        ram_wr  = 1'b1;
        ram_din = ~pat_a;
      end
      default: ;
    endcase
  end

  assign ram_add  = a_q;
  assign busy     = (st_q == WR0) || (st_q == RD1) || (st_q == CK1) ||
                    (st_q == RD2) || (st_q == CK2);
  assign done     = (st_q == DONE);
  assign pass     = pass_q;
  assign fail_add = fail_add_q;
  assign fail_exp = fail_exp_q;
  assign fail_got = fail_got_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with an 8x4 synchronous RAM model that can
// inject a single stuck-at bit on read data.
module tb_ram_bist;

  localparam int DW = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rs;
  logic          start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_add;
  logic [DW-1:0] fail_exp, fail_got;
  logic          ram_wr;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_bist #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rs       (rs),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_add (fail_add),
    .fail_exp (fail_exp),
    .fail_got (fail_got),
    .ram_wr   (ram_wr),
    .ram_add  (ram_add),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // RAM model with optional stuck-at bit0 at one address (read side).
  logic [DW-1:0] mem [8];
  logic          fault_en = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  logic          fault_val = 1'b0;

  // NOTE: the memory array has no reset; the march writes every location
  // before reading it, so power-up contents never matter.
  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = mem[ram_add];
    if (fault_en && ram_add == fault_addr) rd[0] = fault_val;
    ram_dout <= rd;
    if (ram_wr) mem[ram_add] <= ram_din;
  end

  // Access log of every busy cycle plus a count of writes while idle.
  logic [7:0] acc_log [$];
  int         idle_writes = 0;
  always @(negedge clk) begin
    if (busy) acc_log.push_back({ram_wr, ram_add, ram_din});
    if (ram_wr && !busy) idle_writes++;
  end

  function automatic logic [3:0] pat(input int a);
    return (a % 2 == 1) ? 4'b1010 : 4'b0101;
  endfunction

  // Expected {wr, add, din} for busy cycle i of a passing run.
  function automatic logic [7:0] clean_exp(input int i);
    int j;
    if (i < 8) return {1'b1, 3'(i), pat(i)};
    if (i < 24) begin
      j = (i - 8) / 2;
      if ((i - 8) % 2 == 0) return {1'b0, 3'(j), 4'b0000};
      return {1'b1, 3'(j), ~pat(j)};
    end
    j = 7 - (i - 24) / 2;
    return {1'b0, 3'(j), 4'b0000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " pass"}, 32'(pass), 0);
    check({tag, " fail_add"}, 32'(fail_add), 0);
    check({tag, " fail_exp"}, 32'(fail_exp), 0);
    check({tag, " fail_got"}, 32'(fail_got), 0);
    check({tag, " ram_wr"}, 32'(ram_wr), 0);
    check({tag, " ram_add"}, 32'(ram_add), 0);
    check({tag, " ram_din"}, 32'(ram_din), 0);
  endtask

  // Start is accepted on the edge e0 that follows; returns #1 after e0.
  task automatic pulse_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    acc_log.delete();
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts edges after e0 until done (bounded); optionally pokes start
  // so that it is sampled on edges 5 and 20 of the run.
  task automatic wait_done(input bit poke, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (poke) start = (n == 4 || n == 19);
    end while (!done && n < 100);
    if (poke) start = 1'b0;
  endtask

  initial begin
    int n;
    int seq_bad;

    rs    = 1'b0;
    start = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rs = 1'b1;

    // Clean pass with full access-sequence check.
    pulse_start(1'b0);
    check("clean busy after e0", 32'(busy), 1);
    wait_done(1'b0, n);
    check("clean done edge", 32'(n), 40);
    check("clean done", 32'(done), 1);
    check("clean pass", 32'(pass), 1);
    check("clean busy", 32'(busy), 0);
    check("clean fail_add", 32'(fail_add), 0);
    check("clean log size", 32'(acc_log.size()), 40);
    seq_bad = 0;
    for (int i = 0; i < acc_log.size() && i < 40; i++)
      if (acc_log[i] !== clean_exp(i)) seq_bad++;
    check("clean access sequence", 32'(seq_bad), 0);

    // Phase-2 fault: address 3 bit0 stuck at 1.
    fault_en = 1'b1; fault_addr = 3'd3; fault_val = 1'b1;
    pulse_start(1'b0);
    check("p2 done cleared", 32'(done), 0);
    wait_done(1'b0, n);
    check("p2 done edge", 32'(n), 16);
    check("p2 done", 32'(done), 1);
    check("p2 pass", 32'(pass), 0);
    check("p2 fail_add", 32'(fail_add), 3);
    check("p2 fail_exp", 32'(fail_exp), 4'b1010);
    check("p2 fail_got", 32'(fail_got), 4'b1011);
    check("p2 log size", 32'(acc_log.size()), 16);
    check("p2 last access", 32'(acc_log[$]), {1'b1, 3'd3, 4'b0101});
    repeat (3) @(posedge clk);
    #1;
    check("p2 held fail_add", 32'(fail_add), 3);
    check("p2 no idle writes", 32'(idle_writes), 0);

    // Phase-3 fault: address 5 bit0 stuck at 0.
    fault_addr = 3'd5; fault_val = 1'b0;
    pulse_start(1'b0);
    wait_done(1'b0, n);
    check("p3 done edge", 32'(n), 30);
    check("p3 pass", 32'(pass), 0);
    check("p3 fail_add", 32'(fail_add), 5);
    check("p3 fail_exp", 32'(fail_exp), 4'b0101);
    check("p3 fail_got", 32'(fail_got), 4'b0100);
    fault_en = 1'b0;

    // Start pulses while busy are ignored.
    pulse_start(1'b0);
    wait_done(1'b1, n);
    check("busy-start done edge", 32'(n), 40);
    check("busy-start pass", 32'(pass), 1);

    // Asynchronous reset during phase 2.
    pulse_start(1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    #2;
    rs = 1'b0;
    #1;
    check_idle_outputs("midrun reset");
    @(negedge clk);
    rs = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, n);
    check("post-reset done edge", 32'(n), 40);
    check("post-reset pass", 32'(pass), 1);

    // Back-to-back: start held high through DONE.
    pulse_start(1'b1);
    wait_done(1'b0, n);
    check("b2b first done edge", 32'(n), 40);
    check("b2b first pass", 32'(pass), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b done dropped", 32'(done), 0);
    check("b2b busy again", 32'(busy), 1);
    check("b2b pass cleared", 32'(pass), 0);
    wait_done(1'b0, n);
    check("b2b second done edge", 32'(n), 40);
    check("b2b second pass", 32'(pass), 1);
    check("final no idle writes", 32'(idle_writes), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
